// File: rtl/max_pool_sequencer.sv
// Max-pooling sequencer: streams float elements through an external comparator,
// reducing each WINDOW-element group to its maximum, cfg_num_windows groups per run.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module max_pool_sequencer #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int WINDOW     = 4,
    parameter int CNT_WIDTH  = 3,
    parameter int WIN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  flush,
    input  logic [WIN_WIDTH-1:0]  cfg_num_windows,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] cmp_a,
    output logic [DATA_WIDTH-1:0] cmp_b,
    input  logic                  cmp_gt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        ACCUM = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_ELEM = CNT_WIDTH'(WINDOW - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] max_reg;
    logic [CNT_WIDTH-1:0]  elem_cnt;
    logic [WIN_WIDTH-1:0]  win_cnt;
    logic [WIN_WIDTH-1:0]  cfg_reg;

    // Handshake outputs are pure decodes of the state register, so they are
    // glitch-free and all read 0 while reset is asserted.
    assign in_ready  = (state == FIRST) || (state == ACCUM);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign out_data  = max_reg;
    assign cmp_a     = in_data;
    assign cmp_b     = max_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            max_reg  <= '0;
            elem_cnt <= '0;
            win_cnt  <= '0;
            cfg_reg  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state    <= IDLE;
                elem_cnt <= '0;
                win_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (cfg_num_windows == '0) begin
                                done <= 1'b1;
                            end else begin
                                cfg_reg  <= cfg_num_windows;
                                elem_cnt <= '0;
                                win_cnt  <= '0;
                                state    <= FIRST;
                            end
                        end
                    end
                    FIRST: begin
                        // First element seeds the running max without a compare.
                        if (in_valid) begin
                            max_reg  <= in_data;
                            elem_cnt <= CNT_WIDTH'(1);
                            state    <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (in_valid) begin
                            // Strict greater-than: ties keep the earlier element.
                            if (cmp_gt) begin
                                max_reg <= in_data;
                            end
                            if (elem_cnt == LAST_ELEM) begin
                                elem_cnt <= '0;
                                state    <= OUT;
                            end else begin
                                elem_cnt <= elem_cnt + CNT_WIDTH'(1);
                            end
                        end
                    end
                    OUT: begin
                        if (out_ready) begin
                            if (win_cnt == cfg_reg - WIN_WIDTH'(1)) begin
                                win_cnt <= '0;
                                done    <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                win_cnt <= win_cnt + WIN_WIDTH'(1);
                                state   <= FIRST;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_max_pool_sequencer.sv
// Randomized bench for max_pool_sequencer: float comparator and reference
// max-pooling model live here; every transaction is scored against the model.
`timescale 1ns/1ps

module tb_max_pool_sequencer;

    localparam int DW  = 32;
    localparam int WIN = 4;
    localparam int CW  = 3;
    localparam int WW  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          flush;
    logic [WW-1:0] cfg_num_windows;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [DW-1:0] cmp_a;
    logic [DW-1:0] cmp_b;
    logic          cmp_gt;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    logic [31:0] stim_q[$];

    always #5 clk = ~clk;

    max_pool_sequencer #(
        .DATA_WIDTH(DW), .WINDOW(WIN), .CNT_WIDTH(CW), .WIN_WIDTH(WW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .cfg_num_windows(cfg_num_windows),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_gt(cmp_gt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    // IEEE-754 a > b for non-NaN values; +0 and -0 compare equal.
    function automatic bit fgt(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ka;
        logic [31:0] kb;
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
        ka = a[31] ? ~a : (a | 32'h8000_0000);
        kb = b[31] ? ~b : (b | 32'h8000_0000);
        return ka > kb;
    endfunction

    always_comb cmp_gt = fgt(cmp_a, cmp_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_float(input logic [31:0] prev);
        if ($urandom_range(3) == 0) return prev;
        return {1'($urandom_range(1)), 8'($urandom_range(100, 154)), 23'($urandom)};
    endfunction

    task automatic fill(input int nwin);
        logic [31:0] v;
        v = 32'h3F80_0000;
        for (int i = 0; i < nwin * WIN; i++) begin
            v = rand_float(v);
            stim_q.push_back(v);
        end
    endtask

    // One full run: stim_q holds nwin*WIN elements; expected maxima come from the model.
    task automatic do_run(input int nwin, input int vpct, input int rpct,
                          input int hold, input bit spacing);
        logic [31:0] exp_q[$];
        logic [31:0] best;
        logic [31:0] held;
        bit held_v;
        int results, cyc, hs, lat_cyc, last_acc, ostall;
        results = 0; cyc = 0; hs = 0; lat_cyc = -1; last_acc = -1;
        ostall = hold; held_v = 0; held = '0;
        for (int w = 0; w < nwin; w++) begin
            best = stim_q[w * WIN];
            for (int i = 1; i < WIN; i++)
                if (fgt(stim_q[w * WIN + i], best)) best = stim_q[w * WIN + i];
            exp_q.push_back(best);
        end
        @(posedge clk); #1;
        start = 1'b1;
        cfg_num_windows = WW'(nwin);
        @(posedge clk); #1;
        start = 1'b0;
        cfg_num_windows = WW'($urandom);
        while (results < nwin && cyc < 300 * nwin) begin
            in_valid = (stim_q.size() > 0) && ($urandom_range(99) < vpct);
            in_data  = in_valid ? stim_q[0] : $urandom;
            if (out_valid && ostall > 0) begin
                out_ready = 1'b0;
                ostall--;
            end else begin
                out_ready = ($urandom_range(99) < rpct);
            end
            start = ($urandom_range(7) == 0);
            @(negedge clk);
            if (cyc == 0) check("busy_run", busy, 1);
            if (cyc == lat_cyc) check("latency_ov", out_valid, 1);
            if (held_v) check("out_hold", out_data, held);
            check("done_mid", done, 0);
            held_v = 0;
            if (out_valid) begin
                check("in_ready_in_out", in_ready, 0);
                if (out_ready) begin
                    check("pool_max", out_data, exp_q.pop_front());
                    if (spacing && last_acc >= 0) check("spacing", cyc - last_acc, 5);
                    last_acc = cyc;
                    results++;
                end else begin
                    held = out_data;
                    held_v = 1;
                end
            end
            if (in_valid && in_ready) begin
                void'(stim_q.pop_front());
                hs++;
                if (hs % WIN == 0) lat_cyc = cyc + 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("timeout", results, nwin);
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        @(negedge clk);
        check("done_pulse", done, 1);
        check("busy_after", busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_clear", done, 0);
        stim_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; cfg_num_windows = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1'b1;

        // Mixed-sign window, then increasing and all-equal windows.
        stim_q = '{32'h3F00_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h3F00_0000};
        do_run(1, 100, 100, 0, 0);
        stim_q = '{32'h3F00_0000, 32'h3F80_0000, 32'h3FC0_0000, 32'h4000_0000,
                   32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
        do_run(2, 100, 100, 0, 0);

        // Full throughput: results 5 cycles apart.
        fill(3);
        do_run(3, 100, 100, 0, 1);

        // Downstream backpressure for 10 cycles in OUT.
        fill(2);
        do_run(2, 100, 100, 10, 0);

        // Flush after 2 of 4 elements.
        @(posedge clk); #1;
        start = 1'b1; cfg_num_windows = 16'd1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 32'h4100_0000;
        @(posedge clk); #1;
        in_data = 32'h4200_0000;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        check("flush_busy", busy, 0);
        check("flush_in_ready", in_ready, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_done", done, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("flush_done_later", done, 0);
        fill(1);
        do_run(1, 100, 100, 0, 0);

        // Zero-window run.
        @(posedge clk); #1;
        start = 1'b1; cfg_num_windows = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("cfg0_done", done, 1);
        check("cfg0_busy", busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("cfg0_done_clear", done, 0);
        check("cfg0_busy_later", busy, 0);

        // Randomized runs with stalls on both sides.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 5);
            fill(n);
            do_run(n, $urandom_range(40, 100), $urandom_range(30, 100), $urandom_range(0, 4), 0);
        end

        // Asynchronous reset mid-ACCUM.
        @(posedge clk); #1;
        start = 1'b1; cfg_num_windows = 16'd2;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 32'h4080_0000;
        @(posedge clk); #1;
        in_data = 32'h4100_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("accum_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_done", done, 0);
        check("arst_out_data", out_data, 0);
        check("arst_cmp_b", cmp_b, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fill(2);
        do_run(2, 80, 80, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
